// File: rtl/video_irq_watchdog.sv
// video_irq_watchdog: VBLANK interrupt latch, watchdog reset pulse generator
// and one-write-per-unlock EEPROM write gate for the 68010 glue.
module video_irq_watchdog #(
    parameter int WD_W       = 20,
    parameter int WDOG_LIMIT = 458752,
    parameter int RST_PULSE  = 16
) (
    input  logic MCKR,
    input  logic SYSRES_b,
    input  logic VBLANK,
    input  logic VBKACK_b,
    input  logic WDOG_b,
    input  logic WDDIS,
    input  logic UNLOCK_b,
    input  logic E2PROM_b,
    input  logic WL_b,
    output logic VBKINIT_b,
    output logic WDRST_b,
    output logic E2WREN,
    output logic E2WE_b
);
    localparam int PW = $clog2(RST_PULSE + 1);

    typedef enum logic {RUN, FIRE} wd_state_t;

    wd_state_t       state_q, state_d;
    logic [WD_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   pls_q, pls_d;
    logic vb1_q, vb1_d, vb2_q, vb2_d, vb3_q, vb3_d;
    logic ack_h_q, ack_h_d, kick_h_q, kick_h_d, unl_h_q, unl_h_d, e2wr_h_q, e2wr_h_d;
    logic vbkinit_b_q, vbkinit_b_d, wdrst_b_q, wdrst_b_d, e2wren_q, e2wren_d;
    logic rise, fall_ack, kick, unl, e2wr, wr_end;

    // Strobe histories reset high so reset release never looks like a falling edge.
    assign rise     = vb2_q & ~vb3_q;
    assign fall_ack = ~VBKACK_b & ack_h_q;
    assign kick     = ~WDOG_b & kick_h_q;
    assign unl      = ~UNLOCK_b & unl_h_q;
    assign e2wr     = ~E2PROM_b & ~WL_b;
    assign wr_end   = ~e2wr & e2wr_h_q;

    always_comb begin
        vb1_d       = VBLANK;
        vb2_d       = vb1_q;
        vb3_d       = vb2_q;
        ack_h_d     = VBKACK_b;
        kick_h_d    = WDOG_b;
        unl_h_d     = UNLOCK_b;
        e2wr_h_d    = e2wr;
        vbkinit_b_d = rise ? 1'b0 : fall_ack ? 1'b1 : vbkinit_b_q;
        e2wren_d    = unl ? 1'b1 : wr_end ? 1'b0 : e2wren_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        pls_d       = pls_q;
        wdrst_b_d   = wdrst_b_q;
        if (state_q == FIRE) begin
            if (pls_q == PW'(RST_PULSE - 1)) begin
                state_d   = RUN;
                wdrst_b_d = 1'b1;
                cnt_d     = '0;
                pls_d     = '0;
            end else begin
                pls_d = pls_q + 1'b1;
            end
        end else if (WDDIS || kick) begin
            cnt_d = '0;
        end else if (cnt_q == WD_W'(WDOG_LIMIT - 1)) begin
            state_d   = FIRE;
            cnt_d     = '0;
            pls_d     = '0;
            wdrst_b_d = 1'b0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge MCKR or negedge SYSRES_b) begin
        if (!SYSRES_b) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pls_q       <= '0;
            vb1_q       <= 1'b0;
            vb2_q       <= 1'b0;
            vb3_q       <= 1'b0;
            ack_h_q     <= 1'b1;
            kick_h_q    <= 1'b1;
            unl_h_q     <= 1'b1;
            e2wr_h_q    <= 1'b0;
            vbkinit_b_q <= 1'b1;
            wdrst_b_q   <= 1'b1;
            e2wren_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pls_q       <= pls_d;
            vb1_q       <= vb1_d;
            vb2_q       <= vb2_d;
            vb3_q       <= vb3_d;
            ack_h_q     <= ack_h_d;
            kick_h_q    <= kick_h_d;
            unl_h_q     <= unl_h_d;
            e2wr_h_q    <= e2wr_h_d;
            vbkinit_b_q <= vbkinit_b_d;
            wdrst_b_q   <= wdrst_b_d;
            e2wren_q    <= e2wren_d;
        end
    end

    assign VBKINIT_b = vbkinit_b_q;
    assign WDRST_b   = wdrst_b_q;
    assign E2WREN    = e2wren_q;
    assign E2WE_b    = ~(e2wren_q & e2wr);
endmodule

// File: doc/video_irq_watchdog.md
Name: video_irq_watchdog

Overview:
- Sits beside the 68010 address decoder/DTACK glue.
- Consumes the decoder's strobes VBKACK_b, WDOG_b, UNLOCK_b, E2PROM_b and WL_b.
- Produces the VBKINIT_b level interrupt for the '148 priority encoder, a watchdog reset request for the board reset generator (which drives SYSRES_b), and the gated EEPROM write enable.

Parameters:
- WD_W, 20: watchdog counter width.
- WDOG_LIMIT, 458752: MCKR cycles without a kick before the watchdog fires (~64 ms at 7.16 MHz). Must be at least 2.
- RST_PULSE, 16: WDRST_b low width in MCKR cycles. Must be at least 1.

Ports:
- MCKR  in  1  system clock; all logic rises on posedge.
- SYSRES_b  in  1  reset, asynchronous, active-low.
- VBLANK  in  1  vertical blank from video timing, active-high, asynchronous to MCKR.
- VBKACK_b  in  1  decoded VBLANK-ack strobe, active-low, MCKR domain.
- WDOG_b  in  1  decoded watchdog kick strobe, active-low.
- WDDIS  in  1  watchdog disable (self-test jumper), active-high, static.
- UNLOCK_b  in  1  decoded EEPROM unlock strobe, active-low.
- E2PROM_b  in  1  EEPROM select, active-low.
- WL_b  in  1  low-byte write strobe, active-low.
- VBKINIT_b  out  1  VBLANK interrupt request, active-low, latched.
- WDRST_b  out  1  watchdog reset request, active-low pulse.
- E2WREN  out  1  EEPROM write-unlocked flag.
- E2WE_b  out  1  EEPROM write enable to device, active-low.

Behaviour:
- Reset values: VBKINIT_b=1, WDRST_b=1, E2WREN=0, E2WE_b=1, watchdog count=0, watchdog state RUN.
- Reset values of the synchronisers vb1/vb2/vb3: 0.
- Reset values of the strobe-history registers (ack_d, kick_d, unl_d): 1. Release of reset must not create a false falling edge.
- Reset is asynchronous at any time, including mid-FIRE, and returns every register to its reset value.
- VBLANK path:
  - Three-flop chain vb1←VBLANK, vb2←vb1, vb3←vb2; rise = vb2 & ~vb3.
  - VBLANK high at setup of edge n gives VBKINIT_b low after edge n+2.
  - VBKINIT_b stays low until an ack.
- Ack: fall_ack = ~VBKACK_b & ack_d. The edge that samples fall_ack sets VBKINIT_b=1 (1-edge latency).
  - VBKACK_b held low for many cycles counts as a single ack.
  - If rise and fall_ack occur in the same cycle, set wins: VBKINIT_b=0.
- Watchdog FSM has two states, RUN and FIRE.
  - Kick: kick = ~WDOG_b & kick_d.
  - RUN, WDDIS=1: count held at 0, stays in RUN.
  - RUN, WDDIS=0, kick: count←0 for that edge.
  - RUN, WDDIS=0, count==WDOG_LIMIT-1 and no kick: go to FIRE, count←0, WDRST_b←0. If kick and limit coincide, the kick wins.
  - RUN, otherwise: count←count+1.
  - FIRE: WDRST_b held low for exactly RST_PULSE cycles. Kicks and WDDIS are ignored; the pulse always completes.
  - FIRE exit: WDRST_b←1, count←0, return to RUN.
- The count never exceeds WDOG_LIMIT-1 and never wraps.
- EEPROM unlock:
  - unl = ~UNLOCK_b & unl_d sets E2WREN←1.
  - e2wr = ~E2PROM_b & ~WL_b, with e2wr_d its one-cycle history.
  - Write end = ~e2wr & e2wr_d; it clears E2WREN←0.
  - If unl and write end coincide, set wins.
  - E2WE_b = ~(E2WREN & e2wr), combinational. Exactly one write is permitted per unlock.
  - A write without a prior unlock leaves E2WE_b=1.

Test Plan:
- Reset then idle 100 cycles, WDOG_LIMIT=100, WDDIS=1: VBKINIT_b=1, WDRST_b=1, E2WREN=0, E2WE_b=1 throughout.
- VBLANK rises before edge 10: VBKINIT_b low after edge 12. VBKACK_b low at edge 20 for 5 cycles: VBKINIT_b high after edge 20 and stays high. A second VBLANK rise in the same cycle as an ack: VBKINIT_b stays low.
- WDOG_LIMIT=100, RST_PULSE=4, WDDIS=0, kick every 50 cycles for 1000 cycles: WDRST_b never low.
- Kicks stop: WDRST_b low exactly 100 cycles after the last kick, for 4 cycles. A kick during FIRE does not shorten the pulse.
- Kick exactly on the cycle the count reaches 99: no fire.
- E2PROM_b+WL_b write without unlock: E2WE_b stays 1.
- UNLOCK_b strobe, then a 3-cycle write: E2WE_b low 3 cycles, E2WREN drops 1 edge after the write ends. Second write: E2WE_b stays 1.
- SYSRES_b asserted mid-FIRE (2 cycles into the pulse): WDRST_b=1 immediately. After release, the count restarts from 0.
